// File: rtl/round_sequencer_pkg.sv
// Shared types and default sizing for the Memory Matrix round controller.
// The package name is memory_matrix_pkg because the other game blocks share it.
package memory_matrix_pkg;

    // Default geometry: 4x4 board, 8-bit guess budget, 1 s reveal at 50 MHz.
    localparam int DEF_CELLS       = 16;
    localparam int DEF_IDXW        = 4;
    localparam int DEF_GUESS_W     = 8;
    localparam int DEF_SHOW_CYCLES = 50_000_000;

    // Round FSM states. These encodings appear on state_o for the display logic.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHOW  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CHECK = 3'd3,
        ST_WIN   = 3'd4,
        ST_LOSE  = 3'd5
    } state_t;

    // Width of a down-counter that must hold show_cycles-1.
    function automatic int timer_width(input int show_cycles);
        return $clog2(show_cycles) + 1;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Player/display-side signal bundle of the round controller.
// master: the KEY/SW input logic and HEX/LEDR display side.
// slave:  the round_sequencer itself.
interface round_sequencer_if
    import memory_matrix_pkg::*;
#(
    parameter int CELLS   = DEF_CELLS,
    parameter int IDXW    = DEF_IDXW,
    parameter int GUESS_W = DEF_GUESS_W
);
    // Round setup
    logic               start;
    logic [CELLS-1:0]   board;
    logic [GUESS_W-1:0] max_guesses;

    // Guess handshake
    logic               guess_valid;
    logic [IDXW-1:0]    guess_idx;
    logic               guess_ready;

    // Status towards the display
    logic [2:0]         state_o;
    logic               show_board;
    logic [CELLS-1:0]   found_mask;
    logic [GUESS_W-1:0] remaining_guesses;
    logic               last_hit;
    logic               win;
    logic               lose;

    modport master (
        output start, board, max_guesses, guess_valid, guess_idx,
        input  guess_ready, state_o, show_board, found_mask,
               remaining_guesses, last_hit, win, lose
    );

    modport slave (
        input  start, board, max_guesses, guess_valid, guess_idx,
        output guess_ready, state_o, show_board, found_mask,
               remaining_guesses, last_hit, win, lose
    );

endinterface

// File: rtl/round_sequencer_show_timer.sv
// show_timer: loadable down-counter that times the board reveal.
// load has priority over en; the count stops at zero and done stays high there.
module show_timer #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] r_count;

    // Count register: reload on load, otherwise count down to zero while enabled.
    // NOTE: clocked state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: round controller for Memory Matrix.
// Latches the hidden board, reveals it for SHOW_CYCLES cycles, then checks player
// guesses one at a time, tracking found cells and the remaining-guess budget.
// Build option: define REPEAT_FREE_EN to make re-guessing an already-found cell
// free (no charge, no hit); without it such a guess is an ordinary miss.
module round_sequencer
    import memory_matrix_pkg::*;
#(
    parameter int CELLS       = DEF_CELLS,
    parameter int IDXW        = DEF_IDXW,
    parameter int GUESS_W     = DEF_GUESS_W,
    parameter int SHOW_CYCLES = DEF_SHOW_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    round_sequencer_if.slave sif
);

    // State encodings kept as plain constants so legacy display code can match on them.
    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SHOW  = ST_SHOW;
    localparam logic [2:0] S_PLAY  = ST_PLAY;
    localparam logic [2:0] S_CHECK = ST_CHECK;
    localparam logic [2:0] S_WIN   = ST_WIN;
    localparam logic [2:0] S_LOSE  = ST_LOSE;

    localparam int              TW        = timer_width(SHOW_CYCLES);
    localparam logic [TW-1:0]   SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    // CELLS fits in IDXW+1 bits because 2**IDXW >= CELLS.
    localparam logic [IDXW:0]   CELLS_LIM = (IDXW + 1)'(CELLS);
    localparam logic [CELLS-1:0] CELL_ONE = CELLS'(1);

    // Round registers
    logic [2:0]         r_state;
    logic [CELLS-1:0]   r_board;
    logic [CELLS-1:0]   r_found;
    logic [GUESS_W-1:0] r_rem;
    logic [IDXW-1:0]    r_idx;
    logic               r_last_hit;

    // Decode of the current guess and the accept condition
    logic               w_accept;
    logic               w_in_range;
    logic               w_cell_bit;
    logic               w_found_bit;
    logic               w_hit;
    logic               w_free;
    logic [CELLS-1:0]   w_found_nxt;
    logic [GUESS_W-1:0] w_rem_nxt;
    logic [2:0]         w_check_nxt;
    logic               w_timer_done;

    // Reveal timer: loaded when a round starts, runs only while the board is shown.
    show_timer #(
        .W (TW)
    ) u_show_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept),
        .load_val (SHOW_LOAD),
        .en       (r_state == S_SHOW),
        .done     (w_timer_done)
    );

    // Start acceptance and the outcome of the guess held in r_idx.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_accept    = 1'b0;
        w_in_range  = 1'b0;
        w_cell_bit  = 1'b0;
        w_found_bit = 1'b0;
        w_hit       = 1'b0;
        w_free      = 1'b0;
        w_found_nxt = r_found;
        w_rem_nxt   = r_rem;
        w_check_nxt = S_PLAY;

        // A new round may start only from a resting state and with a playable setup.
        if (sif.start && ((r_state == S_IDLE) || (r_state == S_WIN) || (r_state == S_LOSE))
            && (sif.board != '0) && (sif.max_guesses != '0)) begin
            w_accept = 1'b1;
        end

        // Out-of-range indices never hit and never touch found_mask.
        w_in_range = ({1'b0, r_idx} < CELLS_LIM);
        if (w_in_range) begin
            w_cell_bit  = r_board[r_idx];
            w_found_bit = r_found[r_idx];
        end
        w_hit = w_cell_bit & ~w_found_bit;

`ifdef REPEAT_FREE_EN
        // Re-guessing a cell that is already uncovered costs nothing.
        w_free = w_cell_bit & w_found_bit;
`else
        w_free = 1'b0;
`endif

        if (w_hit) begin
            w_found_nxt = r_found | (CELL_ONE << r_idx);
        end

        // Budget saturates at zero.
        if (!w_free) begin
            w_rem_nxt = (r_rem == '0) ? '0 : (r_rem - 1'b1);
        end

        // Completing the board wins even if that guess used the last credit.
        if (w_free) begin
            w_check_nxt = S_PLAY;
        end else if (w_found_nxt == r_board) begin
            w_check_nxt = S_WIN;
        end else if (w_rem_nxt == '0) begin
            w_check_nxt = S_LOSE;
        end else begin
            w_check_nxt = S_PLAY;
        end
    end

    // Round FSM and its registers; reset returns everything to the idle, all-zero state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_board    <= '0;
            r_found    <= '0;
            r_rem      <= '0;
            r_idx      <= '0;
            r_last_hit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WIN, S_LOSE: begin
                    // Results stay on display until a new round is accepted.
                    if (w_accept) begin
                        r_board    <= sif.board;
                        r_rem      <= sif.max_guesses;
                        r_found    <= '0;
                        r_last_hit <= 1'b0;
                        r_state    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_timer_done) begin
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (sif.guess_valid) begin
                        r_idx   <= sif.guess_idx;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_last_hit <= w_hit;
                    r_found    <= w_found_nxt;
                    r_rem      <= w_rem_nxt;
                    r_state    <= w_check_nxt;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode straight from registers, so reset clears them at once.
    assign sif.state_o           = r_state;
    assign sif.show_board        = (r_state == S_SHOW);
    assign sif.guess_ready       = (r_state == S_PLAY);
    assign sif.found_mask        = r_found;
    assign sif.remaining_guesses = r_rem;
    assign sif.last_hit          = r_last_hit;
    assign sif.win               = (r_state == S_WIN);
    assign sif.lose              = (r_state == S_LOSE);

endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: directed rounds with hand-computed results.
// Guess stimulus pushes its expected result into a queue; a monitor pops and
// compares one entry each time the DUT leaves its CHECK state.
module tb_round_sequencer;
    import memory_matrix_pkg::*;

    localparam int CELLS       = 16;
    localparam int IDXW        = 4;
    localparam int GUESS_W     = 8;
    localparam int SHOW_CYCLES = 4;

    localparam logic [2:0] E_IDLE = 3'd0;
    localparam logic [2:0] E_PLAY = 3'd2;
    localparam logic [2:0] E_WIN  = 3'd4;
    localparam logic [2:0] E_LOSE = 3'd5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    round_sequencer_if #(
        .CELLS   (CELLS),
        .IDXW    (IDXW),
        .GUESS_W (GUESS_W)
    ) sif ();

    round_sequencer #(
        .CELLS       (CELLS),
        .IDXW        (IDXW),
        .GUESS_W     (GUESS_W),
        .SHOW_CYCLES (SHOW_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    typedef struct {
        int                 tag;
        logic [CELLS-1:0]   found;
        logic [GUESS_W-1:0] rem;
        logic               hit;
        logic [2:0]         st;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_tag  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input logic [CELLS-1:0] b, input logic [GUESS_W-1:0] m);
        sif.board       = b;
        sif.max_guesses = m;
        sif.start       = 1'b1;
        tick();
        sif.start       = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!sif.guess_ready && n < 40) begin
            tick();
            n++;
        end
        check({name, "_ready"}, 32'(sif.guess_ready), 32'd1);
    endtask

    task automatic guess(input logic [IDXW-1:0] idx, input logic [CELLS-1:0] ef,
                         input logic [GUESS_W-1:0] er, input logic eh, input logic [2:0] es);
        exp_t e;
        wait_ready($sformatf("g%0d", n_tag));
        e.tag   = n_tag;
        e.found = ef;
        e.rem   = er;
        e.hit   = eh;
        e.st    = es;
        n_tag++;
        exp_q.push_back(e);
        sif.guess_idx   = idx;
        sif.guess_valid = 1'b1;
        tick();
        sif.guess_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input logic [2:0] es);
        int n = 0;
        while (sif.state_o == 3'd3 && n < 10) begin
            tick();
            n++;
        end
        check({name, "_end_state"}, 32'(sif.state_o), 32'(es));
    endtask

    // Monitor: the cycle after CHECK carries the result of the popped guess.
    initial begin
        exp_t e;
        bit   was_check = 1'b0;
        forever begin
            @(negedge clk);
            if (was_check) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_check", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("g%0d_found", e.tag), 32'(sif.found_mask), 32'(e.found));
                    check($sformatf("g%0d_rem", e.tag), 32'(sif.remaining_guesses), 32'(e.rem));
                    check($sformatf("g%0d_hit", e.tag), 32'(sif.last_hit), 32'(e.hit));
                    check($sformatf("g%0d_state", e.tag), 32'(sif.state_o), 32'(e.st));
                    check($sformatf("g%0d_win", e.tag), 32'(sif.win), 32'(e.st == E_WIN));
                    check($sformatf("g%0d_lose", e.tag), 32'(sif.lose), 32'(e.st == E_LOSE));
                end
            end
            was_check = (sif.state_o == 3'd3) && !reset;
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_all_zero(input string name);
        check({name, "_state"}, 32'(sif.state_o), 32'd0);
        check({name, "_show"}, 32'(sif.show_board), 32'd0);
        check({name, "_ready0"}, 32'(sif.guess_ready), 32'd0);
        check({name, "_found"}, 32'(sif.found_mask), 32'd0);
        check({name, "_rem"}, 32'(sif.remaining_guesses), 32'd0);
        check({name, "_hit"}, 32'(sif.last_hit), 32'd0);
        check({name, "_winlose"}, 32'({sif.win, sif.lose}), 32'd0);
    endtask

    initial begin
        int cnt;
        int n;
        sif.start       = 1'b0;
        sif.board       = '0;
        sif.max_guesses = '0;
        sif.guess_valid = 1'b0;
        sif.guess_idx   = '0;

        // Reset state
        #12;
        check_all_zero("rst");
        tick();
        reset = 1'b0;

        // Board 0x0003: reveal lasts exactly SHOW_CYCLES cycles, then two hits win.
        start_round(16'h0003, 8'd3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!sif.show_board) break;
            cnt++;
            tick();
        end
        check("t2_show_cycles", 32'(cnt), 32'd4);
        check("t2_ready_after_show", 32'(sif.guess_ready), 32'd1);
        guess(4'd0, 16'h0001, 8'd2, 1'b1, E_PLAY);
        guess(4'd1, 16'h0003, 8'd1, 1'b1, E_WIN);
        wait_end("t2", E_WIN);
        repeat (3) tick();
        check("t2_win_hold", 32'(sif.win), 32'd1);

        // Board 0x0001, three misses exhaust the budget.
        start_round(16'h0001, 8'd3);
        check("t3_win_cleared", 32'(sif.win), 32'd0);
        guess(4'd5, 16'h0000, 8'd2, 1'b0, E_PLAY);
        guess(4'd6, 16'h0000, 8'd1, 1'b0, E_PLAY);
        guess(4'd7, 16'h0000, 8'd0, 1'b0, E_LOSE);
        wait_end("t3", E_LOSE);

        // Single credit, last guess completes the board: win beats lose.
        start_round(16'h0001, 8'd1);
        check("t4_lose_cleared", 32'(sif.lose), 32'd0);
        guess(4'd0, 16'h0001, 8'd0, 1'b1, E_WIN);
        wait_end("t4", E_WIN);

        // Repeat guess of an already-found cell.
        start_round(16'h0003, 8'd3);
        guess(4'd0, 16'h0001, 8'd2, 1'b1, E_PLAY);
`ifdef REPEAT_FREE_EN
        guess(4'd0, 16'h0001, 8'd2, 1'b0, E_PLAY);
`else
        guess(4'd0, 16'h0001, 8'd1, 1'b0, E_PLAY);
`endif

        // Asynchronous reset in the middle of PLAY.
        wait_ready("t1");
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("t1_async");
        tick();
        reset = 1'b0;

        // Unplayable setups are refused.
        start_round(16'h0000, 8'd3);
        check("t6_board0_state", 32'(sif.state_o), 32'(E_IDLE));
        check("t6_board0_show", 32'(sif.show_board), 32'd0);
        start_round(16'h0003, 8'd0);
        check("t6_max0_state", 32'(sif.state_o), 32'(E_IDLE));

        // A guess pulse during the reveal is dropped.
        start_round(16'h0003, 8'd3);
        sif.guess_idx   = 4'd0;
        sif.guess_valid = 1'b1;
        tick();
        sif.guess_valid = 1'b0;
        wait_ready("t6_show_guess");
        check("t6_show_guess_rem", 32'(sif.remaining_guesses), 32'd3);
        check("t6_show_guess_found", 32'(sif.found_mask), 32'd0);

        // start during PLAY is ignored.
        start_round(16'h8000, 8'd1);
        check("t6_start_in_play_state", 32'(sif.state_o), 32'(E_PLAY));
        check("t6_start_in_play_rem", 32'(sif.remaining_guesses), 32'd3);

        // Top index with the top cell set is a hit.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start_round(16'h8000, 8'd3);
        guess(4'hF, 16'h8000, 8'd2, 1'b1, E_WIN);
        wait_end("t6_top", E_WIN);

        // Drain the scoreboard.
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
